// File: rtl/parity_scan_pkg.sv
// rtl/parity_scan_pkg.sv - shared types and constants for the parity scan controller
package parity_scan_pkg;

    localparam int PKG_ADDR_W = 4;
    localparam logic [PKG_ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SCAN_SET = 3'd1,
        ST_SCAN_CHK = 3'd2,
        ST_HOST_SET = 3'd3,
        ST_HOST_CHK = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    typedef enum logic {
        SLOT_SCAN = 1'b0,
        SLOT_HOST = 1'b1
    } slot_t;

endpackage

// File: rtl/parity_eval.sv
// rtl/parity_eval.sv - even-parity check of a data word against its stored parity bit
module parity_eval #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] data,
    input  logic              parity,
    output logic              mismatch
);

    assign mismatch = parity != (^data);

endmodule

// File: rtl/parity_scan_ctrl.sv
// rtl/parity_scan_ctrl.sv - parity scan sequencer with interleaved host reads
module parity_scan_ctrl
    import parity_scan_pkg::*;
#(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 8,
    parameter int ERR_CNT_W = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    input  logic                 host_req,
    input  logic [ADDR_W-1:0]    host_addr,
    output logic                 host_gnt,
    output logic [DATA_W-1:0]    host_data,
    output logic                 host_perr,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [DATA_W-1:0]    mem_data,
    input  logic                 mem_parity,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 err_valid,
    output logic [ADDR_W-1:0]    first_err_addr
);

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(LAST_ADDR);

    state_t              state, state_nxt;
    slot_t               last_slot;
    logic                scan_active;
    logic [ADDR_W-1:0]   scan_ptr;
    logic [ADDR_W-1:0]   host_addr_q;
    logic                mismatch;
    logic                host_wins;

    parity_eval #(.DATA_W(DATA_W)) u_parity_eval (
        .data     (mem_data),
        .parity   (mem_parity),
        .mismatch (mismatch)
    );

    // The grant pulse cycle is blind to host_req so a dropping requester is not re-served.
    assign host_wins = host_req && !host_gnt && (state == ST_IDLE || last_slot != SLOT_HOST);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (host_wins)  state_nxt = ST_HOST_SET;
                else if (start) state_nxt = ST_SCAN_SET;
            end
            ST_SCAN_SET: state_nxt = ST_SCAN_CHK;
            ST_SCAN_CHK: begin
                if (scan_ptr == LAST_PTR) state_nxt = ST_DONE;
                else if (host_wins)       state_nxt = ST_HOST_SET;
                else                      state_nxt = ST_SCAN_SET;
            end
            ST_HOST_SET: state_nxt = ST_HOST_CHK;
            ST_HOST_CHK: state_nxt = scan_active ? ST_SCAN_SET : ST_IDLE;
            ST_DONE:     state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            last_slot      <= SLOT_SCAN;
            scan_active    <= 1'b0;
            scan_ptr       <= '0;
            host_addr_q    <= '0;
            mem_addr       <= '0;
            host_gnt       <= 1'b0;
            host_data      <= '0;
            host_perr      <= 1'b0;
            err_count      <= '0;
            err_valid      <= 1'b0;
            first_err_addr <= '0;
        end else begin
            state    <= state_nxt;
            host_gnt <= 1'b0;
            if (state_nxt == ST_HOST_SET) host_addr_q <= host_addr;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        scan_active    <= 1'b1;
                        scan_ptr       <= '0;
                        err_count      <= '0;
                        err_valid      <= 1'b0;
                        first_err_addr <= '0;
                    end
                end
                ST_SCAN_SET: begin
                    mem_addr  <= scan_ptr;
                    last_slot <= SLOT_SCAN;
                end
                ST_SCAN_CHK: begin
                    if (mismatch) begin
                        if (err_count != '1) err_count <= err_count + 1'b1;
                        if (!err_valid) begin
                            err_valid      <= 1'b1;
                            first_err_addr <= mem_addr;
                        end
                    end
                    if (scan_ptr == LAST_PTR) scan_active <= 1'b0;
                    else                      scan_ptr    <= scan_ptr + 1'b1;
                end
                ST_HOST_SET: begin
                    mem_addr  <= host_addr_q;
                    last_slot <= SLOT_HOST;
                end
                ST_HOST_CHK: begin
                    host_data <= mem_data;
                    host_perr <= mismatch;
                    host_gnt  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = scan_active;
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_parity_scan_ctrl.sv
// tb/tb_parity_scan_ctrl.sv - scoreboard bench for parity_scan_ctrl
module tb_parity_scan_ctrl;

    typedef struct {
        int   edge_n;
        int   cnt;
        logic valid;
        int   first;
    } scan_exp_t;

    typedef struct {
        int         edge_n;
        logic [7:0] data;
        logic       perr;
    } host_exp_t;

    logic       clock = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy, done;
    logic       host_req = 1'b0;
    logic [3:0] host_addr = '0;
    logic       host_gnt;
    logic [7:0] host_data;
    logic       host_perr;
    logic [3:0] mem_addr;
    logic [7:0] mem_data;
    logic       mem_parity;
    logic [4:0] err_count;
    logic       err_valid;
    logic [3:0] first_err_addr;

    logic       s_start = 1'b0;
    logic       s_busy, s_done, s_host_gnt, s_host_perr, s_err_valid;
    logic       s_host_req = 1'b0;
    logic [3:0] s_host_addr = '0;
    logic [7:0] s_host_data, s_mem_data;
    logic [3:0] s_mem_addr, s_first;
    logic       s_mem_parity;
    logic [2:0] s_err_count;

    logic [7:0] mem [16];
    logic       par [16];

    int n_cmp = 0;
    int n_bad = 0;

    scan_exp_t scan_q[$];
    host_exp_t host_q[$];
    int        addr_q[$];

    assign mem_data     = mem[mem_addr];
    assign mem_parity   = par[mem_addr];
    assign s_mem_data   = mem[s_mem_addr];
    assign s_mem_parity = ~(^mem[s_mem_addr]);

    always #5 clock = ~clock;

    parity_scan_ctrl #(.ADDR_W(4), .DATA_W(8), .ERR_CNT_W(5)) dut (
        .clock(clock), .reset(rst_n), .start(start), .busy(busy), .done(done),
        .host_req(host_req), .host_addr(host_addr), .host_gnt(host_gnt),
        .host_data(host_data), .host_perr(host_perr), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_parity(mem_parity), .err_count(err_count),
        .err_valid(err_valid), .first_err_addr(first_err_addr)
    );

    parity_scan_ctrl #(.ADDR_W(4), .DATA_W(8), .ERR_CNT_W(3)) dut_sat (
        .clock(clock), .reset(rst_n), .start(s_start), .busy(s_busy), .done(s_done),
        .host_req(s_host_req), .host_addr(s_host_addr), .host_gnt(s_host_gnt),
        .host_data(s_host_data), .host_perr(s_host_perr), .mem_addr(s_mem_addr),
        .mem_data(s_mem_data), .mem_parity(s_mem_parity), .err_count(s_err_count),
        .err_valid(s_err_valid), .first_err_addr(s_first)
    );

    task automatic fill_mem();
        for (int i = 0; i < 16; i++) begin
            mem[i] = 8'($urandom);
            par[i] = ^mem[i];
        end
        mem[9] = 8'h22;
        par[9] = 1'b0;
    endtask

    task automatic run_scan(output int done_n);
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        done_n = -1;
        for (int i = 1; i <= 120; i++) begin
            @(negedge clock);
            if (done) begin
                done_n = i;
                break;
            end
        end
    endtask

    task automatic host_read(input logic [3:0] a, output int gnt_n,
                             output logic [7:0] d, output logic p);
        @(negedge clock);
        host_req  = 1'b1;
        host_addr = a;
        gnt_n = -1;
        d = '0;
        p = 1'b0;
        for (int i = 0; i <= 20; i++) begin
            @(negedge clock);
            if (host_gnt) begin
                gnt_n = i;
                d = host_data;
                p = host_perr;
                break;
            end
        end
        host_req = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] outs;
        outs = {busy, done, host_gnt, host_data, host_perr, mem_addr, err_count, err_valid, first_err_addr};
        n_cmp++;
        if (outs !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0", outs);
        end
    endtask

    task automatic test_clean_scan();
        scan_exp_t e;
        int        done_n;
        fill_mem();
        scan_q.push_back('{32, 0, 1'b0, 0});
        for (int k = 0; k < 16; k++) addr_q.push_back(k);
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL clean_busy: got %b want 1", busy); end
        done_n = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clock);
            if ((i % 2) == 1 && addr_q.size() > 0) begin
                int a;
                a = addr_q.pop_front();
                n_cmp++;
                if (mem_addr !== 4'(a)) begin
                    n_bad++;
                    $display("FAIL clean_mem_addr: got %0d want %0d", mem_addr, a);
                end
            end
            if (done) begin done_n = i; break; end
        end
        e = scan_q.pop_front();
        n_cmp++;
        if (done_n != e.edge_n || err_count !== 5'(e.cnt) || err_valid !== e.valid || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL clean_done: edge %0d cnt %0d valid %b busy %b want edge %0d cnt %0d valid %b busy 0",
                     done_n, err_count, err_valid, busy, e.edge_n, e.cnt, e.valid);
        end
        @(negedge clock);
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL clean_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_injected_errors();
        scan_exp_t e;
        int        done_n;
        par[5]  = ~par[5];
        par[12] = ~par[12];
        scan_q.push_back('{32, 2, 1'b1, 5});
        run_scan(done_n);
        e = scan_q.pop_front();
        n_cmp++;
        if (done_n != e.edge_n || err_count !== 5'(e.cnt) || err_valid !== e.valid || first_err_addr !== 4'(e.first)) begin
            n_bad++;
            $display("FAIL inject_result: edge %0d cnt %0d valid %b first %0d want %0d %0d %b %0d",
                     done_n, err_count, err_valid, first_err_addr, e.edge_n, e.cnt, e.valid, e.first);
        end
        scan_q.push_back('{32, 2, 1'b1, 5});
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n_cmp++;
        if (err_count !== 5'd0 || err_valid !== 1'b0 || first_err_addr !== 4'd0) begin
            n_bad++;
            $display("FAIL inject_clear: cnt %0d valid %b first %0d want 0 0 0", err_count, err_valid, first_err_addr);
        end
        done_n = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clock);
            if (done) begin done_n = i; break; end
        end
        e = scan_q.pop_front();
        n_cmp++;
        if (done_n != e.edge_n || err_count !== 5'(e.cnt) || first_err_addr !== 4'(e.first)) begin
            n_bad++;
            $display("FAIL inject_rescan: edge %0d cnt %0d first %0d want %0d %0d %0d",
                     done_n, err_count, first_err_addr, e.edge_n, e.cnt, e.first);
        end
    endtask

    task automatic test_idle_host();
        host_exp_t  h;
        int         gnt_n;
        logic [7:0] d;
        logic       p;
        host_q.push_back('{2, 8'h22, 1'b0});
        host_read(4'd9, gnt_n, d, p);
        h = host_q.pop_front();
        n_cmp++;
        if (gnt_n != h.edge_n || d !== h.data || p !== h.perr) begin
            n_bad++;
            $display("FAIL idle_host: edge %0d data %h perr %b want %0d %h %b", gnt_n, d, p, h.edge_n, h.data, h.perr);
        end
        n_cmp++;
        if (err_count !== 5'd2 || err_valid !== 1'b1 || first_err_addr !== 4'd5 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_host_logs: cnt %0d valid %b first %0d busy %b want 2 1 5 0",
                     err_count, err_valid, first_err_addr, busy);
        end
    endtask

    task automatic test_contention();
        scan_exp_t e;
        host_exp_t h;
        int        done_n;
        for (int k = 0; k < 15; k++) host_q.push_back('{4 * k + 4, mem[12], 1'b1});
        scan_q.push_back('{62, 2, 1'b1, 5});
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start     = 1'b0;
        host_req  = 1'b1;
        host_addr = 4'd12;
        done_n = -1;
        for (int i = 1; i <= 120; i++) begin
            @(negedge clock);
            if (host_gnt) begin
                n_cmp++;
                if (host_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL contention_extra_gnt: edge %0d want none", i);
                end else begin
                    h = host_q.pop_front();
                    if (i != h.edge_n || host_data !== h.data || host_perr !== h.perr) begin
                        n_bad++;
                        $display("FAIL contention_gnt: edge %0d data %h perr %b want %0d %h %b",
                                 i, host_data, host_perr, h.edge_n, h.data, h.perr);
                    end
                end
            end
            if (done) begin done_n = i; break; end
        end
        host_req = 1'b0;
        e = scan_q.pop_front();
        n_cmp++;
        if (done_n != e.edge_n || err_count !== 5'(e.cnt) || first_err_addr !== 4'(e.first) || host_q.size() != 0) begin
            n_bad++;
            $display("FAIL contention_done: edge %0d cnt %0d first %0d left %0d want %0d %0d %0d 0",
                     done_n, err_count, first_err_addr, host_q.size(), e.edge_n, e.cnt, e.first);
        end
        host_q.delete();
    endtask

    task automatic test_start_with_host();
        int done_n;
        int gnt_n;
        fill_mem();
        @(negedge clock);
        start     = 1'b1;
        host_req  = 1'b1;
        host_addr = 4'd9;
        @(negedge clock);
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL both_busy: got %b want 1", busy); end
        gnt_n  = -1;
        done_n = -1;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clock);
            if (host_gnt) begin
                gnt_n = i;
                host_req = 1'b0;
                n_cmp++;
                if (host_data !== 8'h22 || host_perr !== 1'b0) begin
                    n_bad++;
                    $display("FAIL both_host_data: data %h perr %b want 22 0", host_data, host_perr);
                end
            end
            if (done) begin done_n = i; break; end
        end
        host_req = 1'b0;
        n_cmp++;
        if (gnt_n != 2 || done_n != 34 || err_count !== 5'd0) begin
            n_bad++;
            $display("FAIL both_timing: gnt %0d done %0d cnt %0d want 2 34 0", gnt_n, done_n, err_count);
        end
    endtask

    task automatic test_saturation();
        int done_n;
        @(negedge clock);
        s_start = 1'b1;
        @(negedge clock);
        s_start = 1'b0;
        done_n = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clock);
            if (s_done) begin done_n = i; break; end
        end
        n_cmp++;
        if (done_n != 32 || s_err_count !== 3'd7 || s_first !== 4'd0 || s_err_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL saturation: edge %0d cnt %0d first %0d valid %b want 32 7 0 1",
                     done_n, s_err_count, s_first, s_err_valid);
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [31:0] outs;
        int          done_seen;
        int          done_n;
        scan_exp_t   e;
        par[5] = ~par[5];
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (15) @(negedge clock);
        n_cmp++;
        if (busy !== 1'b1 || err_count !== 5'd1 || mem_addr !== 4'd7) begin
            n_bad++;
            $display("FAIL midscan_pre: busy %b cnt %0d addr %0d want 1 1 7", busy, err_count, mem_addr);
        end
        rst_n = 1'b0;
        #1;
        outs = {busy, done, host_gnt, host_data, host_perr, mem_addr, err_count, err_valid, first_err_addr};
        n_cmp++;
        if (outs !== 32'h0) begin n_bad++; $display("FAIL midscan_reset: got %h want 0", outs); end
        @(negedge clock);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) done_seen++;
        end
        n_cmp++;
        if (done_seen != 0) begin n_bad++; $display("FAIL midscan_no_done: got %0d want 0", done_seen); end
        scan_q.push_back('{32, 1, 1'b1, 5});
        run_scan(done_n);
        e = scan_q.pop_front();
        n_cmp++;
        if (done_n != e.edge_n || err_count !== 5'(e.cnt) || first_err_addr !== 4'(e.first)) begin
            n_bad++;
            $display("FAIL midscan_rescan: edge %0d cnt %0d first %0d want %0d %0d %0d",
                     done_n, err_count, first_err_addr, e.edge_n, e.cnt, e.first);
        end
    endtask

    initial begin
        fill_mem();
        repeat (3) @(negedge clock);
        rst_n = 1'b1;
        test_reset();
        test_clean_scan();
        test_injected_errors();
        test_idle_host();
        test_contention();
        test_start_with_host();
        test_saturation();
        test_reset_mid_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
